// File: rtl/booth_mult_seq.sv
// Sequential signed 8x8 -> 16-bit radix-2 Booth multiplier.
// booth_mult_seq runs one Booth iteration per clock through a single
// eight_bit_as adder/subtractor and returns {A,Q} as the signed product.
//
// Handshake: start is sampled on a rising clk edge only while the block is
// ready (IDLE or the DONE cycle); an accepted start captures a and b, and busy
// is high from the next cycle through the last iteration. done is a one-cycle
// pulse in the cycle after the last iteration, with product valid from that
// same cycle. start seen while busy is ignored. product holds its value until
// the next result is written or reset is asserted.

// 8-bit two's-complement adder/subtractor: r = a + b (opcode=0) or a - b (opcode=1).
module eight_bit_as (
    output logic [7:0] r,
    output logic       cout,
    output logic       overflow,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       opcode
);

    logic [7:0] b_eff;
    logic [8:0] full_sum;

    // Subtraction is a + ~b + 1; signed overflow when both addends share a sign the result lacks.
    always_comb begin
        b_eff    = b ^ {8{opcode}};
        full_sum = {1'b0, a} + {1'b0, b_eff} + {8'b0, opcode};
        r        = full_sum[7:0];
        cout     = full_sum[8];
        overflow = (a[7] == b_eff[7]) && (full_sum[7] != a[7]);
    end

endmodule

module booth_mult_seq #(
    parameter int N = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Control state and registered outputs.
    state_t      state_q;
    logic        busy_q;
    logic        done_q;
    logic [15:0] product_q;

    // Booth datapath: A accumulator, Q multiplier, M multiplicand, q_m1 extra bit.
    logic [7:0]  acc_q;
    logic [7:0]  mplr_q;
    logic [7:0]  mcand_q;
    logic        qm1_q;
    logic [3:0]  count_q;

    // Next-iteration values of the datapath.
    logic [7:0]  acc_d;
    logic [7:0]  mplr_d;
    logic        qm1_d;

    // Adder/subtractor interface.
    logic [7:0]  as_r;
    logic        as_cout_unused;
    logic        as_ovf;
    logic        as_opcode;

    // Iteration decode.
    logic [1:0]  booth_pair;
    logic        do_op;
    logic [7:0]  sum;
    logic        true_sign;
    logic        last_iter;

    eight_bit_as u_as (
        .r        (as_r),
        .cout     (as_cout_unused),
        .overflow (as_ovf),
        .a        (acc_q),
        .b        (mcand_q),
        .opcode   (as_opcode)
    );

    // One Booth step: pick add/sub/skip from {Q[0],q_m1}, then shift {A,Q,q_m1}
    // right arithmetically using a sign corrected for adder overflow, so that
    // M = -128 still yields the exact product.
    always_comb begin
        booth_pair = {mplr_q[0], qm1_q};
        do_op      = booth_pair[1] ^ booth_pair[0];
        as_opcode  = booth_pair[1];
        sum        = do_op ? as_r : acc_q;
        true_sign  = do_op ? (as_r[7] ^ as_ovf) : acc_q[7];
        acc_d      = {true_sign, sum[7:1]};
        mplr_d     = {sum[0], mplr_q[7:1]};
        qm1_d      = mplr_q[0];
        last_iter  = (count_q == 4'(N - 1));
    end

    // Controller FSM with datapath updates and registered busy/done/product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= 16'h0000;
            acc_q     <= 8'h00;
            mplr_q    <= 8'h00;
            mcand_q   <= 8'h00;
            qm1_q     <= 1'b0;
            count_q   <= 4'd0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        mcand_q <= a;
                        mplr_q  <= b;
                        acc_q   <= 8'h00;
                        qm1_q   <= 1'b0;
                        count_q <= 4'd0;
                        busy_q  <= 1'b1;
                        state_q <= S_CALC;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_CALC: begin
                    acc_q   <= acc_d;
                    mplr_q  <= mplr_d;
                    qm1_q   <= qm1_d;
                    count_q <= count_q + 4'd1;
                    if (last_iter) begin
                        product_q <= {acc_d, mplr_d};
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= S_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
- Sequential signed 8x8 -> 16-bit multiplier controller; radix-2 Booth algorithm.
- Owns a single eight_bit_as instance and drives it once per cycle for 8 iterations: add, subtract or skip, then arithmetic shift.
- Sits beside the adder/subtractor as its sequencer; exposes a start/busy/done handshake to the requester.

Parameters:
- N, 8, operand width; fixed at 8 to match eight_bit_as. Iteration count = N.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled on rising clk when ready to accept.
- a  input  8  signed multiplicand, two's complement; captured on accepted start.
- b  input  8  signed multiplier, two's complement; captured on accepted start.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse when product becomes valid.
- product  output  16  signed result {A,Q}; held until the next result is written.

Behaviour:
- Reset: rst_n low forces, without waiting for clk, state=IDLE, busy=0, done=0, product=16'h0000, A=0, Q=0, M=0, q_m1=0, count=0.
  - Applies mid-operation: the computation is abandoned and no done is produced.
- Datapath registers: A[7:0] accumulator, Q[7:0] multiplier, q_m1 extra bit, M[7:0] multiplicand, count[3:0].
- eight_bit_as connection, port order (r, cout, overflow, a, b, opcode):
  - a input = A; b input = M.
  - opcode = 0 for add, 1 for subtract.
  - cout is unused.
- States: IDLE, CALC, DONE.
- IDLE:
  - On start=1: load M=a, Q=b, A=0, q_m1=0, count=0; go to CALC; busy=1 from the next cycle.
  - On start=0: stay in IDLE.
- CALC, one iteration per cycle:
  - {Q[0],q_m1}=01: sum = A+M.
  - {Q[0],q_m1}=10: sum = A-M.
  - {Q[0],q_m1}=00 or 11: sum = A; the adder output is ignored.
  - Shift: true_sign = sum[7] XOR overflow when an add/sub was performed, else A[7].
  - Update: {A,Q,q_m1} <= {true_sign, sum, Q}. This is an arithmetic right shift of the 17-bit value using the corrected sign.
  - The overflow correction is required so that M=-128 gives the correct result.
  - count increments each iteration. The iteration with count=7 is the last: go to DONE and write product <= {A_next, Q_next} on the same edge.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - start=1 here is accepted as in IDLE: back-to-back operation with no dead cycle.
  - Otherwise return to IDLE.
- Timing: start accepted at edge E0; iterations at E1..E8; done=1 and product valid after E8; done drops after E9. Latency from start to done is 8 cycles after acceptance.
- start while busy=1 is ignored. a/b changes during CALC have no effect because operands are captured.
- product changes only on the final-iteration edge or on reset. It is not cleared at start.
- Arithmetic: result is exact two's complement for all 65536 input pairs; no saturation; no overflow output (a 16-bit product cannot overflow).

Test Plan:
- a=3, b=5, pulse start -> busy high for 8 cycles, done pulse at cycle 9 after start, product=16'h000F (15).
- a=-128, b=-128 -> product=16'h4000 (16384), which exercises the overflow-corrected sign. Also a=-128, b=127 -> product=16'hC080 (-16256).
- a=-7, b=6 -> 16'hFFD6 (-42). Then a=0, b=-1 -> 16'h0000. Then a=127, b=127 -> 16'h3F01 (16129).
- Pulse start again at cycle 4 of a run with different a/b -> ignored; the first product is unchanged and only one done is produced.
- Assert rst_n=0 asynchronously mid-CALC (between edges) -> busy/done/product go to 0 immediately; no done after release; a new start after release computes correctly.
- Hold start=1 continuously with changing operands -> the second op is accepted in the DONE cycle, done pulses every 9 cycles, and each product matches a*b.
- Random soak: 1000 random signed pairs compared against a*b reference.
